// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C configuration slave
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    SUB,
    ACK_SUB,
    DATA,
    ACK_DATA,
    IGNORE
  } i2c_state_e;

  // The block owns the bus from an accepted address until STOP.
  function automatic logic is_busy(i2c_state_e s);
    return s inside {ACK_ADDR, SUB, ACK_SUB, DATA, ACK_DATA};
  endfunction

  // States in which the slave holds SDA low for one SCL low period.
  function automatic logic is_ack(i2c_state_e s);
    return s inside {ACK_ADDR, ACK_SUB, ACK_DATA};
  endfunction

  // States in which a byte is being shifted in.
  function automatic logic is_rx(i2c_state_e s);
    return s inside {ADDR, SUB, DATA};
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF synchronizer plus consecutive-sample glitch filter with edge strobes
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic line_in,
  output logic line_f,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; resets to the idle-high bus level
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) {s1, s2} <= 2'b11;
    else            {s1, s2} <= {line_in, s1};

  // Accept a new level only after FILT_LEN consecutive disagreeing samples; strobe the edge with it
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      line_f <= 1'b1;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == line_f) cnt <= '0;
      else if (cnt == CW'(FILT_LEN - 1)) begin
        line_f <= s2;
        cnt    <= '0;
        rise   <= s2;
        fall   <= !s2;
      end else cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/i2c_cfg_slave.sv
// i2c_cfg_slave: write-only I2C slave producing {sub-address, data} register write pulses
module i2c_cfg_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h1A,
  parameter int                    FILT_LEN   = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i2c_sclk,
  input  logic              i2c_sda_in,
  output logic              i2c_sda_oe,
  output logic              wr_valid,
  output logic [BYTE_W-1:0] wr_sub_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic              busy,
  output logic              err_trunc
);

  logic              scl, scl_rise, scl_fall;
  logic              sda, sda_rise, sda_fall;
  logic              sda_old, start, stop, addr_ok, hi;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] sr, ptr;
  i2c_state_e        state;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .line_in  (i2c_sclk),
    .line_f   (scl),
    .rise     (scl_rise),
    .fall     (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .line_in  (i2c_sda_in),
    .line_f   (sda),
    .rise     (sda_rise),
    .fall     (sda_fall)
  );

  // SDA as it was before this cycle, so an SCL edge coinciding with an SDA edge samples old data
  assign sda_old = sda_rise ? 1'b0 : sda_fall ? 1'b1 : sda;
  // An SDA edge only counts as START/STOP when SCL is steadily high, not rising in the same cycle
  assign start   = sda_fall && scl && !scl_rise;
  assign stop    = sda_rise && scl && !scl_rise;
  assign addr_ok = sr[BYTE_W-1:1] == SLAVE_ADDR && !sr[0];
  assign busy    = is_busy(state);

  // Protocol FSM: bits sampled on SCL rise, counted on the following fall (hi marks a sampled bit)
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      hi          <= 1'b0;
      sr          <= '0;
      ptr         <= '0;
      i2c_sda_oe  <= 1'b0;
      wr_valid    <= 1'b0;
      wr_sub_addr <= '0;
      wr_data     <= '0;
      err_trunc   <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      err_trunc <= 1'b0;
      if (start || stop) begin
        state      <= start ? ADDR : IDLE;
        bit_cnt    <= '0;
        hi         <= 1'b0;
        i2c_sda_oe <= 1'b0;
        err_trunc  <= is_rx(state) && bit_cnt != 3'd0;
      end else if (is_rx(state)) begin
        if (scl_rise) begin
          sr <= {sr[BYTE_W-2:0], sda_old};
          hi <= 1'b1;
        end else if (scl_fall && hi) begin
          hi      <= 1'b0;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state      <= state == SUB ? ACK_SUB : state == DATA ? ACK_DATA : addr_ok ? ACK_ADDR : IGNORE;
            i2c_sda_oe <= state != ADDR || addr_ok;
          end
        end
      end else if (is_ack(state) && scl_fall) begin
        i2c_sda_oe <= 1'b0;
        state      <= state == ACK_ADDR ? SUB : DATA;
        if (state == ACK_SUB) ptr <= sr;
        if (state == ACK_DATA) begin
          wr_valid    <= 1'b1;
          wr_sub_addr <= ptr;
          wr_data     <= sr;
          ptr         <= ptr + 8'd1;
        end
      end
    end

endmodule

// File: doc/i2c_cfg_slave.md
I2C_CFG_SLAVE -- requirements
Module: i2c_cfg_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h1A, the 7-bit device address this block answers.
REQ-002 Parameter FILT_LEN, default 3, the number of consecutive equal sys_clk samples needed to accept a new SCL/SDA level.
REQ-003 sys_clk  input  1  system clock, 50 MHz; reset sys_rst_n, asynchronous, active-low; clock sys_clk.
REQ-004 sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 i2c_sclk  input  1  bus SCL, asynchronous to sys_clk.
REQ-006 i2c_sda_in  input  1  bus SDA read-back, asynchronous to sys_clk.
REQ-007 i2c_sda_oe  output  1  when 1, the top-level pad drives SDA low; when 0, SDA is released (open-drain).
REQ-008 wr_valid  output  1  one-cycle pulse marking a completed register write.
REQ-009 wr_sub_addr  output  8  register sub-address; valid while wr_valid=1.
REQ-010 wr_data  output  8  register data; valid while wr_valid=1.
REQ-011 busy  output  1  high from an addressed START until STOP.
REQ-012 err_trunc  output  1  one-cycle pulse when STOP or repeated START aborts a partially received byte.

Function
REQ-013 SCL and SDA shall pass through a 2-FF synchronizer, then a FILT_LEN glitch filter; total pin-to-internal latency is 2+FILT_LEN sys_clk cycles.
REQ-014 START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while filtered SCL is high. Both are detected in any state.
REQ-015 Data bits are sampled MSB-first on the filtered SCL rising edge, and bit_cnt counts 0..7.
REQ-016 The state machine has states IDLE, ADDR, ACK_ADDR, SUB, ACK_SUB, DATA, ACK_DATA and IGNORE.
REQ-017 IDLE goes to ADDR on START.
REQ-018 In ADDR, after 8 bits, the block goes to ACK_ADDR if addr[7:1]==SLAVE_ADDR and R/W==0; otherwise it goes to IGNORE.
REQ-019 ACK slots: i2c_sda_oe rises on the filtered SCL falling edge after bit 8 and falls on the next filtered SCL falling edge.
REQ-020 IGNORE never asserts i2c_sda_oe (this NACKs reads and foreign addresses) and exits only on START or STOP.
REQ-021 ACK_ADDR goes to SUB; ACK_SUB goes to DATA, with the sub-address pointer loaded from the byte received in SUB.
REQ-022 In DATA, after 8 bits the block goes to ACK_DATA; at the end of the ACK slot it pulses wr_valid for one cycle with the current {pointer, byte}, then returns to DATA.
REQ-023 The pointer increments after each wr_valid, wrapping 8'hFF to 8'h00.
REQ-024 A STOP shall move the block to IDLE from any state; a repeated START shall move it to ADDR from any state.
REQ-025 If bit_cnt is 1..7 when a STOP or repeated START arrives, the block pulses err_trunc, discards the partial byte and does not pulse wr_valid.
REQ-026 On STOP or repeated START, i2c_sda_oe drops in the same cycle.
REQ-027 busy=1 in ACK_ADDR, SUB, ACK_SUB, DATA and ACK_DATA; busy=0 in IDLE, ADDR and IGNORE.
REQ-028 A START and STOP in the same cycle cannot occur (SDA has one edge per cycle); SCL and SDA edges in the same filtered cycle shall be treated as an SCL edge with the old SDA.

Reset
REQ-029 On reset assertion: state=IDLE, bit_cnt=0, pointer=0, i2c_sda_oe=0, wr_valid=0, err_trunc=0, busy=0, wr_sub_addr=0, wr_data=0.
REQ-030 Synchronizer and filter flops shall reset to 1 (bus idle), so reset release causes no false START.
REQ-031 Reset mid-transfer releases SDA immediately (asynchronously), and the block ignores the bus until the next START.

Structure
REQ-032 The state enum, the I2C_ADDR_W=7 constant and the byte width belong in the shared package i2c_pkg.
REQ-033 One sub-module, i2c_line_filter (synchronizer + glitch filter + rise/fall strobes), shall be instantiated twice, once for SCL and once for SDA.

Verification
REQ-034 Write 0x34,0x0E,0x4A at 20 kHz SCL -> three ACKs; exactly one wr_valid with sub=0x0E, data=0x4A; busy falls on STOP.
REQ-035 Write 0x34,0xFF,0x11,0x22 -> wr_valid twice: (0xFF,0x11) then (0x00,0x22), showing the wrap.
REQ-036 Address 0x36, then address 0x35 (read) -> SDA never pulled low, no wr_valid, busy stays 0.
REQ-037 STOP after 4 bits of the data byte -> err_trunc pulses, no wr_valid, state returns to IDLE.
REQ-038 A 1-cycle SDA glitch while SCL is high, plus reset asserted mid-ACK -> no START/STOP detected from the glitch; on reset i2c_sda_oe=0 within the reset cycle and the next transfer completes normally.
